risc240_muldiv_unit: RTL and testbench

Iterative multiply/divide coprocessor for the RISC240 datapath. It generalises the current fixed 8x8 multiplier to a WIDTH-bit operand unit with unsigned/signed multiply and unsigned divide. It uses a start/done handshake driven by the controlpath. The datapath presents operands from the register file and writes the registered result back when done pulses.

---
 rtl/risc240_muldiv_unit_pkg.sv | 23 ++
 rtl/risc240_muldiv_unit_if.sv | 28 ++
 rtl/risc240_muldiv_unit_addsub.sv | 18 +
 rtl/risc240_muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_risc240_muldiv_unit.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/risc240_muldiv_unit_pkg.sv
// Shared types for the RISC240 multiply/divide coprocessor: operation modes,
// FSM states and the mode-remap helper used when an operation is accepted.
package risc240_muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULU = 2'b00,
        MD_MULS = 2'b01,
        MD_DIVU = 2'b10,
        MD_RSVD = 2'b11
    } muldiv_mode_t;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_CALC   = 2'b01,
        MD_FINISH = 2'b10
    } muldiv_state_t;

    // The reserved encoding runs as an unsigned multiply.
    function automatic muldiv_mode_t f_exec_mode(input muldiv_mode_t m);
        return (m == MD_RSVD) ? MD_MULU : m;
    endfunction

endpackage

// File: rtl/risc240_muldiv_unit_if.sv
// Start/done handshake and operand/result bus between the RISC240
// controlpath/datapath (master) and the multiply/divide unit (slave).
interface risc240_muldiv_unit_if
    import risc240_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic                 start;
    muldiv_mode_t         mode;
    logic [WIDTH-1:0]     srcA;
    logic [WIDTH-1:0]     srcB;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 div_by_zero;

    modport master (
        output start, mode, srcA, srcB,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, mode, srcA, srcB,
        output busy, done, result, div_by_zero
    );

endinterface

// File: rtl/risc240_muldiv_unit_addsub.sv
// (WIDTH+1)-bit adder/subtractor shared by the shift-add multiply step and
// the restoring-divide trial subtract. o_cout=1 on subtract means no borrow.
module muldiv_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_b,
    input  logic           i_sub,
    output logic [WIDTH:0] o_sum,
    output logic           o_cout
);

    logic [WIDTH:0] w_b;

    assign w_b = i_sub ? ~i_b : i_b;
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, w_b} + {{(WIDTH+1){1'b0}}, i_sub};

endmodule

// File: rtl/risc240_muldiv_unit.sv
// Iterative WIDTH-bit multiply (unsigned/signed) and unsigned divide unit.
// Optional macro MULDIV_EARLY_TERM_EN: multiply finishes early once the
// remaining multiplier bits are all zero.
//
// state     | meaning
// MD_IDLE   | waiting for start; operands latched on accept
// MD_CALC   | one shift-add / restoring-divide iteration per clock
// MD_FINISH | sign fix-up or divide-by-zero forcing, done pulse
module risc240_muldiv_unit
    import risc240_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    risc240_muldiv_unit_if.slave  bus
);

    localparam int                 CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]      COUNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]   ONE_W      = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W     = (2*WIDTH)'(1);

    muldiv_state_t        r_state;
    muldiv_state_t        w_state_nxt;
    muldiv_mode_t         r_mode;
    logic                 r_neg;
    logic [CW-1:0]        r_count;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dbz;

    logic                 w_is_div;
    logic                 w_last;
    logic                 w_early;
    logic [WIDTH:0]       w_as_a;
    logic [WIDTH:0]       w_as_b;
    logic [WIDTH:0]       w_sum;
    logic                 w_cout;
    logic [2*WIDTH-1:0]   w_mul_step;
    logic [2*WIDTH-1:0]   w_div_step;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + ONE_W) : v;
    endfunction

    assign w_is_div = (r_mode == MD_DIVU);
    assign w_last   = (r_count == COUNT_ONE);

`ifdef MULDIV_EARLY_TERM_EN
    assign w_early  = !w_is_div && (r_mplier == '0);
`else
    assign w_early  = 1'b0;
`endif

    // Divide works on {rem, next dividend bit} as a WIDTH+1-bit value so the
    // bit shifted out of rem is never lost.
    assign w_as_a = w_is_div ? r_acc[2*WIDTH-1:WIDTH-1]
                             : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_as_b = w_is_div ? {1'b0, r_mplier}
                             : {1'b0, (r_mplier[0] ? r_mcand : {WIDTH{1'b0}})};

    muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .i_a    (w_as_a),
        .i_b    (w_as_b),
        .i_sub  (w_is_div),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_mul_step = {w_sum, r_acc[WIDTH-1:1]};
    assign w_div_step = w_cout ? {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                               : {r_acc[2*WIDTH-2:0], 1'b0};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE:   if (bus.start) w_state_nxt = MD_CALC;
            MD_CALC:   if (w_early || w_last) w_state_nxt = MD_FINISH;
            MD_FINISH: w_state_nxt = MD_IDLE;
            default:   w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode   <= MD_MULU;
            r_neg    <= 1'b0;
            r_count  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (bus.start) begin
                        r_mode  <= f_exec_mode(bus.mode);
                        r_neg   <= (bus.mode == MD_MULS) &&
                                   (bus.srcA[WIDTH-1] ^ bus.srcB[WIDTH-1]);
                        if (bus.mode == MD_MULS) begin
                            r_mcand  <= f_mag(bus.srcA);
                            r_mplier <= f_mag(bus.srcB);
                        end else begin
                            r_mcand  <= bus.srcA;
                            r_mplier <= bus.srcB;
                        end
                        r_acc   <= (bus.mode == MD_DIVU) ? {{WIDTH{1'b0}}, bus.srcA} : '0;
                        r_count <= COUNT_INIT;
                        r_busy  <= 1'b1;
                        r_dbz   <= 1'b0;
                    end
                end
                MD_CALC: begin
                    if (w_early) begin
                        // No adds remain, so the outstanding shifts collapse into one.
                        r_acc   <= r_acc >> r_count;
                        r_count <= '0;
                    end else begin
                        r_acc   <= w_is_div ? w_div_step : w_mul_step;
                        if (!w_is_div) r_mplier <= r_mplier >> 1;
                        r_count <= r_count - COUNT_ONE;
                    end
                end
                MD_FINISH: begin
                    if (w_is_div && (r_mplier == '0)) begin
                        r_result <= {r_mcand, {WIDTH{1'b1}}};
                        r_dbz    <= 1'b1;
                    end else if ((r_mode == MD_MULS) && r_neg) begin
                        r_result <= ~r_acc + ONE_2W;
                    end else begin
                        r_result <= r_acc;
                    end
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_risc240_muldiv_unit.sv
// Self-checking bench for risc240_muldiv_unit (WIDTH=8): transaction-level
// model compared every cycle, plus directed literal expectations.
module tb_risc240_muldiv_unit;
    import risc240_muldiv_unit_pkg::*;

    localparam int W = 8;
`ifdef MULDIV_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    risc240_muldiv_unit_if #(.WIDTH(W)) bus ();

    risc240_muldiv_unit #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic int sgn8(input logic [7:0] v);
        return v[7] ? int'(v) - 256 : int'(v);
    endfunction

    function automatic logic [7:0] mag8(input logic [7:0] v);
        int s;
        s = sgn8(v);
        return 8'(s < 0 ? -s : s);
    endfunction

    function automatic int bitlen(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    // Transaction-level model: result from plain arithmetic, done after a
    // latency counted in clock edges from the accepting edge.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dbz = 1'b0;
    logic [15:0] m_result = 16'h0;
    logic [15:0] m_pend = 16'h0;
    logic        m_pend_dbz = 1'b0;
    int          m_left = 0;
    int          m_a, m_b, m_k;
    logic [7:0]  m_cb;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_result = 16'h0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    m_result = m_pend; m_dbz = m_pend_dbz;
                end
            end else if (bus.start) begin
                m_a = int'(bus.srcA);
                m_b = int'(bus.srcB);
                m_cb = bus.srcB;
                m_pend_dbz = 1'b0;
                case (bus.mode)
                    MD_MULS: begin
                        m_pend = 16'(sgn8(bus.srcA) * sgn8(bus.srcB));
                        m_cb = mag8(bus.srcB);
                    end
                    MD_DIVU: begin
                        if (m_b == 0) begin
                            m_pend = {bus.srcA, 8'hFF}; m_pend_dbz = 1'b1;
                        end else begin
                            m_pend = {8'(m_a % m_b), 8'(m_a / m_b)};
                        end
                    end
                    default: m_pend = 16'(m_a * m_b);
                endcase
                m_left = W + 1;
                if (ET && bus.mode != MD_DIVU) begin
                    m_k = bitlen(m_cb);
                    m_left = ((m_k == W) ? W : m_k + 1) + 1;
                end
                m_busy = 1'b1; m_dbz = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        chk("busy",   32'(bus.busy),        32'(m_busy));
        chk("done",   32'(bus.done),        32'(m_done));
        chk("result", 32'(bus.result),      32'(m_result));
        chk("dbz",    32'(bus.div_by_zero), 32'(m_dbz));
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run(input muldiv_mode_t md, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input logic exp_dbz, input int lat,
                       input int inj, input string nm);
        int n;
        logic got;
        bus.mode = md; bus.srcA = a; bus.srcB = b; bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            if (n + 1 == inj) begin
                bus.start = 1'b1; bus.mode = MD_MULU; bus.srcA = 8'h55; bus.srcB = 8'h66;
            end else begin
                bus.start = 1'b0; bus.srcA = ~a; bus.srcB = ~b;
            end
            @(posedge clock);
            n++;
            @(negedge clock);
            if (bus.done) got = 1'b1;
        end
        bus.start = 1'b0;
        chk({nm, "_latency"}, 32'(n), 32'(lat));
        chk({nm, "_result"},  32'(bus.result), 32'(exp));
        chk({nm, "_dbz"},     32'(bus.div_by_zero), 32'(exp_dbz));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.mode = MD_MULU; bus.srcA = 8'h00; bus.srcB = 8'h00;
        repeat (2) @(negedge clock);
        chk("reset_busy",   32'(bus.busy), 32'd0);
        chk("reset_done",   32'(bus.done), 32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);
        chk("reset_dbz",    32'(bus.div_by_zero), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run(MD_MULU, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 9, -1, "mulu_ff_ff");
        @(negedge clock);
        run(MD_MULS, 8'hFD, 8'h05, 16'hFFF1, 1'b0, ET ? 5 : 9, -1, "muls_m3_5");
        @(negedge clock);
        run(MD_MULS, 8'h80, 8'h80, 16'h4000, 1'b0, 9, -1, "muls_80_80");
        @(negedge clock);
        run(MD_MULS, 8'h80, 8'h01, 16'hFF80, 1'b0, ET ? 3 : 9, -1, "muls_80_01");
        @(negedge clock);
        run(MD_MULS, 8'h07, 8'hFE, 16'hFFF2, 1'b0, ET ? 4 : 9, -1, "muls_7_m2");
        @(negedge clock);
        run(MD_DIVU, 8'hC8, 8'h07, 16'h041C, 1'b0, 9, -1, "divu_c8_07");
        @(negedge clock);
        run(MD_DIVU, 8'h2A, 8'h00, 16'h2AFF, 1'b1, 9, -1, "divu_by_zero");
        @(negedge clock);

        // Ignored start at edge 4, then a back-to-back start in the done cycle.
        run(MD_MULU, 8'h03, 8'h04, 16'h000C, 1'b0, ET ? 5 : 9, 4, "mulu_ignore");
        run(MD_MULU, 8'h07, 8'h02, 16'h000E, 1'b0, ET ? 4 : 9, -1, "mulu_b2b");
        @(negedge clock);

        // Reset in the middle of a divide.
        bus.mode = MD_DIVU; bus.srcA = 8'h64; bus.srcB = 8'h03; bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy",   32'(bus.busy), 32'd0);
        chk("abort_done",   32'(bus.done), 32'd0);
        chk("abort_result", 32'(bus.result), 32'd0);
        chk("abort_dbz",    32'(bus.div_by_zero), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (15) begin
            @(negedge clock);
            chk("abort_no_done", 32'(bus.done), 32'd0);
        end

        run(MD_MULU, 8'h05, 8'h00, 16'h0000, 1'b0, ET ? 2 : 9, -1, "mulu_5_0");
        @(negedge clock);
        run(MD_DIVU, 8'h64, 8'h03, 16'h0121, 1'b0, 9, -1, "divu_64_03");
        @(negedge clock);
        run(MD_RSVD, 8'h10, 8'h0F, 16'h00F0, 1'b0, ET ? 6 : 9, -1, "rsvd_as_mulu");
        @(negedge clock);
        run(MD_DIVU, 8'h05, 8'h09, 16'h0500, 1'b0, 9, -1, "divu_5_9");
        @(negedge clock);
        run(MD_MULU, 8'h00, 8'hFF, 16'h0000, 1'b0, 9, -1, "mulu_0_ff");
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
